// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the fetch front end.
// Latency: none (declarations only).
// Backpressure: n/a.
package fetch_buffer_pkg;

  // Width of one instruction word returned by instruction memory.
  localparam int INSNBITS_SIZE = 32;

  // An all-zero word is the halt marker.
  function automatic logic is_halt_word(input logic [INSNBITS_SIZE-1:0] w);
    return (w == '0);
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundles the imem, dispatch and ROB-redirect signals of the fetch buffer.
// Latency: none (wires only).
// Backpressure: dispatch stalls via in_d_stall; imem has no backpressure.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int PC_W  = 64,
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     out_imem_req;
  logic [PC_W-1:0]          out_imem_addr;
  logic [INSNBITS_SIZE-1:0] in_imem_data;
  logic                     in_d_stall;
  logic                     out_d_done;
  logic [INSNBITS_SIZE-1:0] out_d_insnbits;
  logic [PC_W-1:0]          out_d_pc;
  logic                     in_rob_is_mispred;
  logic [PC_W-1:0]          in_rob_target_pc;
  logic                     out_halted;
  logic [CNT_W-1:0]         out_count;

  // Fetch buffer side.
  modport slave (
    output out_imem_req, out_imem_addr, out_d_done, out_d_insnbits, out_d_pc,
           out_halted, out_count,
    input  in_imem_data, in_d_stall, in_rob_is_mispred, in_rob_target_pc
  );

  // Environment side (imem, dispatch, ROB).
  modport master (
    input  out_imem_req, out_imem_addr, out_d_done, out_d_insnbits, out_d_pc,
           out_halted, out_count,
    output in_imem_data, in_d_stall, in_rob_is_mispred, in_rob_target_pc
  );

endinterface

// File: rtl/fetch_buffer_insn_fifo.sv
// Circular buffer of fetched entries; head is read straight from storage.
// Latency: push visible at head the cycle after it is written.
// Backpressure: none internally; caller must not push when full (credit-guarded).
module insn_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [95:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  entry_t                       push_dat,
  input  logic                         pop,
  input  logic                         clear,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output entry_t                       head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop on an empty queue is ignored; clear overrides both push and pop.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: PC, sequential imem requests, response queue presented to dispatch.
// Latency: request in cycle N reaches dispatch in cycle N+2 on an empty queue.
// Backpressure: requests issue only while occupancy + in-flight < DEPTH.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic           in_clk,
  input logic           in_rst_n,
  fetch_buffer_if.slave io
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSNBITS_SIZE-1:0] insnbits;
    logic [PC_W-1:0]          pc;
  } fetch_entry_t;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            inflight_q, inflight_d;
  logic            halted_q, halted_d;

  logic            req;
  logic            resp_live;
  logic            halt_seen;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;

  // Credit: every in-flight request owns a slot, so the queue can never overflow.
  assign credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
  assign req = in_rst_n && !halted_q && !io.in_rob_is_mispred
               && (credit_used < (CNT_W+1)'(DEPTH));

  // A response counts only if not squashed by a redirect and fetch is still running.
  assign resp_live  = inflight_q && !io.in_rob_is_mispred && !halted_q;
  assign halt_seen  = resp_live && is_halt_word(io.in_imem_data);
  assign fifo_push  = resp_live && !is_halt_word(io.in_imem_data);
  assign fifo_pop   = !fifo_empty && !io.in_d_stall && !io.in_rob_is_mispred;
  assign push_entry = '{insnbits: io.in_imem_data, pc: pend_pc_q};

  insn_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk      (in_clk),
    .rst_n    (in_rst_n),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .clear    (io.in_rob_is_mispred),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  // Outputs: head fields are masked when the queue is empty so idle outputs read zero.
  assign io.out_imem_req   = req;
  assign io.out_imem_addr  = pc_q;
  assign io.out_d_done     = !fifo_empty;
  assign io.out_d_insnbits = fifo_empty ? '0 : fifo_head.insnbits;
  assign io.out_d_pc       = fifo_empty ? '0 : fifo_head.pc;
  assign io.out_halted     = halted_q;
  assign io.out_count      = fifo_count;

  // Next-state: redirect wins; otherwise advance PC on request and latch halt.
  always_comb begin
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    inflight_d = req;
    halted_d   = halted_q;
    if (io.in_rob_is_mispred) begin
      pc_d     = io.in_rob_target_pc;
      halted_d = 1'b0;
    end else begin
      if (req) begin
        pc_d      = pc_q + PC_W'(4);
        pend_pc_d = pc_q;
      end
      if (halt_seen) halted_d = 1'b1;
    end
  end

  // Front-end state registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  // Overflow would mean the credit rule is broken.
  always_ff @(posedge in_clk) begin
    if (in_rst_n) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

endmodule
